// File: rtl/sfcw_sweep_ctrl.sv
// rtl/sfcw_sweep_ctrl.sv - step-frequency sweep sequencer for the SFCW receive chain
//
// Steps the LO tuning word through n_steps frequencies. At each step it waits out
// the settle time, integrates the signed IF samples, then offers the per-step sum
// downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, abort          sweep request (sampled in IDLE) / terminate sweep
//   f_start, f_step       first tuning word / increment per step
//   n_steps               number of frequency steps (0 gives an empty sweep)
//   settle_cycles         settle count per step (SETTLE lasts settle_cycles+1)
//   n_samples             IF samples integrated per step (0 acts as 1)
//   if_in                 signed mixer IF sample
//   lo_ftw, lo_valid      registered LO tuning word / new-step pulse
//   busy                  high while a sweep is in progress
//   acc_out, acc_step     per-step integrated IF and its step index
//   acc_valid, acc_ready  result handshake
//   sweep_done            one-cycle pulse at normal completion
module sfcw_sweep_ctrl #(
  parameter int FREQ_WIDTH   = 32,
  parameter int IF_WIDTH     = 32,
  parameter int ACC_WIDTH    = 48,
  parameter int STEP_WIDTH   = 10,
  parameter int SAMP_WIDTH   = 12,
  parameter int SETTLE_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [FREQ_WIDTH-1:0]        f_start,
  input  logic [FREQ_WIDTH-1:0]        f_step,
  input  logic [STEP_WIDTH-1:0]        n_steps,
  input  logic [SETTLE_WIDTH-1:0]      settle_cycles,
  input  logic [SAMP_WIDTH-1:0]        n_samples,
  input  logic signed [IF_WIDTH-1:0]   if_in,
  output logic [FREQ_WIDTH-1:0]        lo_ftw,
  output logic                         lo_valid,
  output logic                         busy,
  output logic signed [ACC_WIDTH-1:0]  acc_out,
  output logic [STEP_WIDTH-1:0]        acc_step,
  output logic                         acc_valid,
  input  logic                         acc_ready,
  output logic                         sweep_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_INTEG  = 3'd2;
  localparam logic [2:0] S_OUTPUT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [STEP_WIDTH-1:0]   STEP_ONE   = 1;
  localparam logic [SAMP_WIDTH-1:0]   SAMP_ONE   = 1;
  localparam logic [SETTLE_WIDTH-1:0] SETTLE_ONE = 1;

  logic [2:0]                  state;
  logic [FREQ_WIDTH-1:0]       f_step_q;
  logic [STEP_WIDTH-1:0]       n_steps_q;
  logic [SETTLE_WIDTH-1:0]     settle_q;
  logic [SAMP_WIDTH-1:0]       n_samp_q;
  logic [STEP_WIDTH-1:0]       step_idx;
  logic [SETTLE_WIDTH-1:0]     settle_cnt;
  logic [SAMP_WIDTH-1:0]       samp_cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;

  // Size cast of a signed operand sign-extends; the add wraps modulo 2^ACC_WIDTH.
  assign acc_next = acc + ACC_WIDTH'(if_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      f_step_q   <= '0;
      n_steps_q  <= '0;
      settle_q   <= '0;
      n_samp_q   <= '0;
      step_idx   <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      acc        <= '0;
      lo_ftw     <= '0;
      lo_valid   <= 1'b0;
      busy       <= 1'b0;
      acc_out    <= '0;
      acc_step   <= '0;
      acc_valid  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      lo_valid   <= 1'b0;
      sweep_done <= 1'b0;
      if (abort && state != S_IDLE) begin
        // lo_ftw deliberately holds so the LO stays where the sweep stopped.
        state     <= S_IDLE;
        busy      <= 1'b0;
        acc_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              f_step_q  <= f_step;
              n_steps_q <= n_steps;
              settle_q  <= settle_cycles;
              n_samp_q  <= n_samples;
              busy      <= 1'b1;
              if (n_steps == '0) begin
                state      <= S_DONE;
                sweep_done <= 1'b1;
              end else begin
                lo_ftw     <= f_start;
                lo_valid   <= 1'b1;
                step_idx   <= '0;
                settle_cnt <= settle_cycles;
                state      <= S_SETTLE;
              end
            end
          end
          S_SETTLE: begin
            if (settle_cnt == '0) begin
              acc      <= '0;
              samp_cnt <= (n_samp_q == '0) ? SAMP_ONE : n_samp_q;
              state    <= S_INTEG;
            end else begin
              settle_cnt <= settle_cnt - SETTLE_ONE;
            end
          end
          S_INTEG: begin
            acc      <= acc_next;
            samp_cnt <= samp_cnt - SAMP_ONE;
            if (samp_cnt == SAMP_ONE) begin
              // Publish the sum including this cycle's sample directly.
              acc_out   <= acc_next;
              acc_step  <= step_idx;
              acc_valid <= 1'b1;
              state     <= S_OUTPUT;
            end
          end
          S_OUTPUT: begin
            if (acc_ready) begin
              acc_valid <= 1'b0;
              if (step_idx == n_steps_q - STEP_ONE) begin
                state      <= S_DONE;
                sweep_done <= 1'b1;
              end else begin
                step_idx   <= step_idx + STEP_ONE;
                lo_ftw     <= lo_ftw + f_step_q;
                lo_valid   <= 1'b1;
                settle_cnt <= settle_q;
                state      <= S_SETTLE;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            acc_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfcw_sweep_ctrl.sv
// tb/tb_sfcw_sweep_ctrl.sv - self-checking bench for sfcw_sweep_ctrl
module tb_sfcw_sweep_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [31:0]        f_start = '0;
  logic [31:0]        f_step = '0;
  logic [9:0]         n_steps = '0;
  logic [15:0]        settle_cycles = '0;
  logic [11:0]        n_samples = '0;
  logic signed [31:0] if_in = '0;
  logic               acc_ready = 1'b0;
  logic [31:0]        lo_ftw;
  logic               lo_valid;
  logic               busy;
  logic signed [47:0] acc_out;
  logic [9:0]         acc_step;
  logic               acc_valid;
  logic               sweep_done;

  sfcw_sweep_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .f_start       (f_start),
    .f_step        (f_step),
    .n_steps       (n_steps),
    .settle_cycles (settle_cycles),
    .n_samples     (n_samples),
    .if_in         (if_in),
    .lo_ftw        (lo_ftw),
    .lo_valid      (lo_valid),
    .busy          (busy),
    .acc_out       (acc_out),
    .acc_step      (acc_step),
    .acc_valid     (acc_valid),
    .acc_ready     (acc_ready),
    .sweep_done    (sweep_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Stimulus knobs
  bit                 if_rand = 1'b0;
  logic signed [31:0] if_const = 32'sd0;
  int                 ready_pct = 100;
  bit                 bp_en = 1'b0;
  int                 bp_until = -1;
  bit                 scramble = 1'b0;
  logic signed [31:0] if_log [0:65535];

  // Reference model: a sweep is a list of steps; step k's LO value is
  // f_start + k*f_step, its result appears settle+1+n cycles after its LO
  // pulse, and its sum is the IF samples present during those n cycles.
  int                 mode = 0;   // 0 idle, 1 sweeping, 2 done-pulse cycle
  int                 k, t_lo, t_v, n_starts;
  int                 m_n, m_set, m_neff;
  logic [31:0]        m_fs, m_fst;
  logic [31:0]        exp_ftw = '0;
  logic signed [47:0] exp_sum = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic signed [47:0] sum_window(input int from, input int n);
    logic signed [47:0] s;
    s = '0;
    for (int j = 0; j < n; j++) s += 48'($signed(if_log[(from + j) % 65536]));
    return s;
  endfunction

  task automatic model_step();
    logic e_lo, e_av, e_done, e_busy;
    e_lo   = (mode == 1 && cyc == t_lo);
    e_av   = (mode == 1 && cyc >= t_v);
    e_done = (mode == 2);
    e_busy = (mode != 0);
    if (e_lo) exp_ftw = m_fs + 32'(k) * m_fst;
    if (mode == 1 && cyc == t_v) exp_sum = sum_window(t_lo + m_set + 1, m_neff);
    chk("lo_valid", lo_valid, e_lo);
    chk("busy", busy, e_busy);
    chk("acc_valid", acc_valid, e_av);
    chk("sweep_done", sweep_done, e_done);
    chk("lo_ftw", lo_ftw, exp_ftw);
    if (e_av) begin
      chk("acc_out", acc_out, exp_sum);
      chk("acc_step", acc_step, k);
    end
    if (mode != 0 && abort) mode = 0;
    else if (mode == 2) mode = 0;
    else if (mode == 0) begin
      if (start && !abort) begin
        n_starts++;
        m_fs   = f_start;
        m_fst  = f_step;
        m_n    = n_steps;
        m_set  = settle_cycles;
        m_neff = (n_samples == 0) ? 1 : int'(n_samples);
        k      = 0;
        if (m_n == 0) mode = 2;
        else begin
          mode = 1;
          t_lo = cyc + 1;
          t_v  = t_lo + m_set + m_neff + 1;
        end
      end
    end else if (e_av && acc_ready) begin
      if (k == m_n - 1) mode = 2;
      else begin
        k++;
        t_lo = cyc + 1;
        t_v  = t_lo + m_set + m_neff + 1;
      end
    end
  endtask

  task automatic cycle(input logic st, input logic ab);
    @(posedge clk);
    #1;
    cyc++;
    start = st;
    abort = ab;
    if (scramble) begin
      f_start       = $urandom;
      f_step        = $urandom;
      n_steps       = 10'($urandom_range(0, 3));
      settle_cycles = 16'($urandom_range(0, 3));
      n_samples     = 12'($urandom_range(0, 3));
    end
    if_in = if_rand ? $signed($urandom) : if_const;
    if (bp_en && mode == 1 && cyc == t_v) bp_until = cyc + 9;
    acc_ready = (cyc <= bp_until) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
    if_log[cyc % 65536] = if_in;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fst, input int ns,
                           input int st, input int nsm, input int abort_rel,
                           input bit hold, input bit scr);
    int   budget, s0;
    logic ab;
    f_start       = fs;
    f_step        = fst;
    n_steps       = 10'(ns);
    settle_cycles = 16'(st);
    n_samples     = 12'(nsm);
    n_starts      = 0;
    scramble      = 1'b0;
    cycle(1'b1, 1'b0);
    scramble = scr;
    s0       = cyc + 1;
    budget   = 2000;
    while ((mode != 0 || (hold && n_starts < 2)) && budget > 0) begin
      ab = (abort_rel >= 0 && cyc + 1 == s0 + abort_rel);
      cycle(hold && n_starts < 2, ab);
      budget--;
    end
    if (budget == 0) chk("sweep_timeout", 1, 0);
    scramble = 1'b0;
    idle(2);
  endtask

  task automatic check_outputs_zero(input string pfx);
    chk({pfx, "_lo_ftw"}, lo_ftw, 0);
    chk({pfx, "_lo_valid"}, lo_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_acc_out"}, acc_out, 0);
    chk({pfx, "_acc_step"}, acc_step, 0);
    chk({pfx, "_acc_valid"}, acc_valid, 0);
    chk({pfx, "_sweep_done"}, sweep_done, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_outputs_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle(2);

    // Nominal sweep: 1000/1100/1200, sums of 20, first result at cycle 8.
    if_const = 32'sd5;
    run_sweep(32'd1000, 32'd100, 3, 2, 4, -1, 1'b0, 1'b0);

    // Backpressure: ready low for 10 cycles at each result.
    bp_en = 1'b1;
    if_rand = 1'b1;
    run_sweep(32'd1000, 32'd100, 2, 1, 3, -1, 1'b0, 1'b0);
    bp_en = 1'b0;
    bp_until = -1;

    // Sign extension.
    if_rand = 1'b0;
    if_const = -32'sd3;
    run_sweep(32'd7, 32'd1, 1, 0, 4, -1, 1'b0, 1'b0);

    // Abort in INTEG, then a full sweep.
    if_const = 32'sd7;
    run_sweep(32'd500, 32'd10, 3, 2, 4, 4, 1'b0, 1'b0);
    run_sweep(32'd500, 32'd10, 3, 2, 4, -1, 1'b0, 1'b0);

    // Boundaries.
    if_rand = 1'b1;
    run_sweep(32'd123, 32'd1, 0, 3, 3, -1, 1'b0, 1'b0);
    run_sweep(32'd10, 32'd1, 2, 1, 0, -1, 1'b0, 1'b0);
    run_sweep(32'hFFFF_FFF0, 32'h20, 2, 1, 1, -1, 1'b0, 1'b0);
    chk("wrap_ftw", lo_ftw, 32'h0000_0010);

    // Held start re-triggers after DONE.
    run_sweep(32'd40, 32'd4, 2, 0, 2, -1, 1'b1, 1'b0);

    // Randomized sweeps.
    for (int i = 0; i < 40; i++) begin
      ready_pct = $urandom_range(40, 100);
      run_sweep($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 5),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1,
                $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
    end
    ready_pct = 100;

    // Asynchronous reset in SETTLE.
    f_start = 32'd900; f_step = 32'd9; n_steps = 10'd2;
    settle_cycles = 16'd8; n_samples = 12'd2;
    cycle(1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode = 0;
    exp_ftw = '0;
    @(negedge clk);
    idle(2);
    run_sweep(32'd77, 32'd3, 2, 1, 2, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sfcw_sweep_ctrl.md
# sfcw_sweep_ctrl

Step-frequency sweep sequencer for the SFCW receive chain. On `start` it steps the LO tuning word through `n_steps` frequencies. For each step it waits a programmable settle time, then coherently integrates the signed IF samples from the mixer over `n_samples` clocks. It hands each per-step sum downstream through a valid/ready handshake. It sits between the register/config interface and the LO NCO and mixer, and feeds the range-FFT buffer.

## Interface
- `FREQ_WIDTH`, 32, LO frequency tuning word width
- `IF_WIDTH`, 32, mixer IF sample width (signed)
- `ACC_WIDTH`, 48, accumulator/result width (signed), ≥ IF_WIDTH
- `STEP_WIDTH`, 10, width of step count and step index
- `SAMP_WIDTH`, 12, width of samples-per-step count
- `SETTLE_WIDTH`, 16, width of settle count

- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: sweep request; sampled only in IDLE
- `abort` in 1: terminate sweep; valid in any state
- `f_start` in FREQ_WIDTH: first tuning word
- `f_step` in FREQ_WIDTH: tuning word increment per step
- `n_steps` in STEP_WIDTH: number of frequency steps
- `settle_cycles` in SETTLE_WIDTH: settle count per step
- `n_samples` in SAMP_WIDTH: IF samples integrated per step
- `if_in` in IF_WIDTH signed: mixer output
- `lo_ftw` out FREQ_WIDTH: LO tuning word, registered
- `lo_valid` out 1: one-cycle pulse when `lo_ftw` takes a new step value
- `busy` out 1: high whenever state ≠ IDLE
- `acc_out` out ACC_WIDTH signed: per-step integrated IF
- `acc_step` out STEP_WIDTH: step index of `acc_out`
- `acc_valid` out 1: result valid
- `acc_ready` in 1: downstream accept
- `sweep_done` out 1: one-cycle pulse at normal sweep completion

## Operation
- States: IDLE, SETTLE, INTEG, OUTPUT, DONE. All outputs are registered.
- Reset: state IDLE. All outputs are 0, including `lo_ftw`, `acc_out`, `acc_step` and both pulses. Reset mid-sweep clears everything immediately.
- IDLE:
  - `start`=1 latches `f_start`, `f_step`, `n_steps`, `settle_cycles` and `n_samples`. Later input changes are ignored until the next start.
  - If the latched `n_steps`=0, go to DONE. `lo_valid` does not pulse and `acc_valid` does not assert.
  - Otherwise: `lo_ftw`←`f_start`, `lo_valid`←1, step index←0, settle counter←`settle_cycles`, then go to SETTLE.
- SETTLE:
  - If the counter is 0, clear the accumulator, load the sample counter and go to INTEG. Otherwise decrement.
  - SETTLE therefore lasts `settle_cycles`+1 cycles. This covers the mixer's 1-cycle registered latency.
- INTEG:
  - Each cycle, the accumulator += sign-extended `if_in`.
  - It runs for exactly `n_samples` cycles; `n_samples`=0 is treated as 1.
  - After the last sample, go to OUTPUT.
- OUTPUT:
  - `acc_valid`=1, with `acc_out` = sum and `acc_step` = step index.
  - `acc_out` and `acc_step` hold stable until `acc_valid`&`acc_ready`.
  - On handshake, `acc_valid`←0. If step index = `n_steps`−1, go to DONE.
  - Otherwise: step index+1, `lo_ftw`←`lo_ftw`+`f_step`, `lo_valid`←1, settle counter reloads, then go to SETTLE.
- DONE: `sweep_done`=1 for one cycle, then go to IDLE.
- Arithmetic:
  - The `lo_ftw` increment wraps modulo 2^FREQ_WIDTH.
  - The accumulator wraps modulo 2^ACC_WIDTH with no saturation.
- `abort`:
  - From any non-IDLE state, at the next edge: go to IDLE; `acc_valid`, `busy` and `lo_valid` go to 0; `sweep_done` does not pulse; `lo_ftw` holds its value.
  - `abort` beats a simultaneous handshake, and also beats `start` in IDLE.
- `start` while `busy` is ignored. `start` held high re-triggers a new sweep on the first IDLE cycle after DONE.

## Timing
- Take start as sampled at edge 0, with `n_steps`≥1:
  - Cycle 1: `lo_valid`=1, `lo_ftw`=`f_start`, `busy`=1.
  - Cycles 1 … `settle_cycles`+1: SETTLE.
  - Next `n_samples` cycles: INTEG.
  - Following cycle: `acc_valid`=1.
- Per-step period with `acc_ready` tied high is `settle_cycles`+1+`n_samples`+1 cycles.
- After the final handshake cycle, `sweep_done` is high for the next cycle. `busy` is low the cycle after that.
- `lo_valid` rises in the same cycle that `lo_ftw` changes.
- `acc_valid` is never high in the same cycle as `lo_valid`.

## Test plan
- Nominal sweep, with `f_start`=1000, `f_step`=100, `n_steps`=3, `settle_cycles`=2, `n_samples`=4, `if_in`=5 constant, `acc_ready`=1:
  - `lo_ftw` goes 1000, 1100, 1200, each with a `lo_valid` pulse.
  - `acc_out`=20 with `acc_step` 0, 1, 2.
  - First `acc_valid` is at cycle 8.
  - Exactly one `sweep_done` pulse.
- Backpressure: hold `acc_ready`=0 for 10 cycles in OUTPUT -> `acc_valid`, `acc_out` and `acc_step` are stable, `lo_ftw` is unchanged, and the step advances one cycle after ready rises.
- Sign: `if_in`=−3, `n_samples`=4 -> `acc_out`=−12, correctly sign-extended to 48 bits.
- Abort in INTEG, then restart:
  - `busy`=0 the next cycle.
  - No `acc_valid` and no `sweep_done`.
  - A following `start` runs a full correct sweep from `f_start`.
- Boundaries:
  - `n_steps`=0 -> `sweep_done` pulse with no `lo_valid` and no `acc_valid`.
  - `n_samples`=0 -> single-sample sum.
  - `f_start`=0xFFFFFFF0, `f_step`=0x20 -> second `lo_ftw`=0x00000010.
- Asynchronous reset mid-SETTLE -> all outputs 0 without waiting for a clock edge, and state returns to IDLE.
